// File: rtl/debug_uart_tx_fifo.sv
// Buffered 8N1 transmitter for the debug UART: CPU byte writes land in a small
// circular FIFO and are serialised back-to-back on a registered uart_txd.
module debug_uart_tx_fifo #(
  parameter int CLK_HZ     = 64_000_000,
  parameter int BIT_RATE   = 4_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [7:0]                         wr_data,
  input  logic                               clr_overflow,
  output logic                               uart_txd,
  output logic                               full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               busy,
  output logic                               overflow
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [CW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            txd_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;

  logic            push, pop, baud_last;

  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign busy      = (state_q != IDLE) || (level_q != '0);
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign uart_txd  = txd_q;

  assign baud_last = (baud_q == BAUD_LAST);
  assign push      = wr_en && !full;
  // Pops only ever look at the registered level, so a byte written this cycle waits one edge.
  assign pop       = (level_q != '0) &&
                     ((state_q == IDLE) || ((state_q == STOP) && baud_last));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // txd_q follows the state one cycle later, so the line lags the FSM by exactly one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shreg_q[bit_q];
        default: txd_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (level_q != '0) begin
            shreg_q <= mem_q[rd_ptr_q];
            state_q <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (level_q != '0) begin
              shreg_q <= mem_q[rd_ptr_q];
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
